// File: rtl/hack_pkg.sv
// Shared HACK CPU types and constants used by the PC, fetch and decode stages.
package hack_pkg;

  localparam int HACK_ADDR_W = 16;
  localparam int HACK_DATA_W = 16;

  typedef logic [HACK_ADDR_W-1:0] hack_addr_t;
  typedef logic [HACK_DATA_W-1:0] hack_word_t;

  localparam hack_addr_t HACK_RESET_PC = 16'h0000;

  // The one-entry buffer can take a new word when empty or being drained.
  function automatic logic fetch_space(input logic buf_valid, input logic buf_ready);
    return !buf_valid || buf_ready;
  endfunction

endpackage

// File: rtl/hack_fetch_if.sv
// Fetch-stage bus bundle: PC load path, ROM handshake, instruction stream,
// redirect and error flag. master = fetch stage, slave = its environment.
interface hack_fetch_if
  import hack_pkg::*;
#(
  parameter int ADDR_W = HACK_ADDR_W,
  parameter int DATA_W = HACK_DATA_W
);

  logic [ADDR_W-1:0] pc_addr;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;

  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ack;
  logic [DATA_W-1:0] rom_data;

  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  logic              fetch_err;

  modport master (
    input  pc_addr,
    output pc_load, pc_load_val,
    output rom_req, rom_addr,
    input  rom_ack, rom_data,
    output instr, instr_pc, instr_valid,
    input  instr_ready,
    input  redirect, redirect_pc,
    output fetch_err
  );

  modport slave (
    output pc_addr,
    input  pc_load, pc_load_val,
    input  rom_req, rom_addr,
    output rom_ack, rom_data,
    input  instr, instr_pc, instr_valid,
    output instr_ready,
    output redirect, redirect_pc,
    input  fetch_err
  );

endinterface

// File: rtl/hack_fetch_watchdog.sv
// ROM ack watchdog: counts consecutive stalled request cycles and raises a
// sticky fetch_err once the count reaches TIMEOUT_CYCLES.
module hack_fetch_watchdog
  import hack_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  input  logic clear,
  output logic fetch_err
);

  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT_CYCLES - 32'd1);

  logic [CNT_W-1:0] count_r;
  logic             err_r;
  logic             hit_s;

  assign hit_s     = stall && (count_r == LIMIT_M1);
  assign fetch_err = err_r;

  // Stall counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
      err_r   <= 1'b0;
    end else if (clear) begin
      count_r <= '0;
      err_r   <= err_r;
    end else if (stall && !err_r) begin
      count_r <= count_r + CNT_W'(1);
      err_r   <= err_r | hit_s;
    end else begin
      count_r <= count_r;
      err_r   <= err_r;
    end
  end

endmodule

// File: rtl/hack_fetch.sv
// HACK instruction-fetch stage: ROM req/ack fetch, one-entry instruction buffer,
// PC control via load path. Optional ack watchdog under HACK_FETCH_TIMEOUT_EN.
module hack_fetch
  import hack_pkg::*;
#(
  parameter int          ADDR_W         = HACK_ADDR_W,
  parameter int          DATA_W         = HACK_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  hack_fetch_if.master  bus
);

  logic [DATA_W-1:0] instr_r;
  logic [ADDR_W-1:0] instr_pc_r;
  logic              instr_valid_r;

  logic              space_s;
  logic              rom_req_s;
  logic              xfer_s;
  logic              pc_load_s;
  logic [ADDR_W-1:0] pc_load_val_s;
  logic              err_s;

`ifdef HACK_FETCH_TIMEOUT_EN
  hack_fetch_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .stall     (rom_req_s && !bus.rom_ack),
    .clear     (xfer_s || bus.redirect),
    .fetch_err (err_s)
  );
`else
  assign err_s = 1'b0;
`endif

  // Request/PC control; reset, then redirect, then normal fetch.
  always_comb begin
    space_s       = fetch_space(instr_valid_r, bus.instr_ready);
    rom_req_s     = 1'b0;
    xfer_s        = 1'b0;
    pc_load_s     = 1'b1;
    pc_load_val_s = bus.pc_addr;
    if (reset) begin
      pc_load_val_s = ADDR_W'(HACK_RESET_PC);
    end else if (bus.redirect) begin
      // Any ack seen this cycle is dropped; the PC jumps instead.
      pc_load_val_s = bus.redirect_pc;
    end else begin
      rom_req_s = space_s && !err_s;
      xfer_s    = rom_req_s && bus.rom_ack;
      // Reloading pc_addr holds the PC; releasing load lets it increment.
      pc_load_s = !xfer_s;
    end
  end

  // One-entry instruction buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_r       <= '0;
      instr_pc_r    <= '0;
      instr_valid_r <= 1'b0;
    end else if (bus.redirect) begin
      instr_r       <= instr_r;
      instr_pc_r    <= instr_pc_r;
      instr_valid_r <= 1'b0;
    end else if (xfer_s) begin
      instr_r       <= bus.rom_data;
      instr_pc_r    <= bus.pc_addr;
      instr_valid_r <= 1'b1;
    end else if (bus.instr_ready && instr_valid_r) begin
      instr_r       <= instr_r;
      instr_pc_r    <= instr_pc_r;
      instr_valid_r <= 1'b0;
    end else begin
      instr_r       <= instr_r;
      instr_pc_r    <= instr_pc_r;
      instr_valid_r <= instr_valid_r;
    end
  end

  assign bus.rom_req     = rom_req_s;
  assign bus.rom_addr    = bus.pc_addr;
  assign bus.pc_load     = pc_load_s;
  assign bus.pc_load_val = pc_load_val_s;
  assign bus.instr       = instr_r;
  assign bus.instr_pc    = instr_pc_r;
  assign bus.instr_valid = instr_valid_r;
  assign bus.fetch_err   = err_s;

endmodule

// File: doc/hack_fetch.md
Name: hack_fetch

Overview:
- Instruction-fetch stage directly downstream of the program counter register. It reads the current PC value and issues a ROM read with a req/ack handshake.
- It captures the returned word into a one-entry instruction buffer and presents it to the decode/execute stage with valid/ready.
- It controls PC advance through the PC's load/data_in path. Holding the PC means reloading its own value; advancing means letting it increment. Jumps and redirects also go through that path.

Parameters:
- ADDR_W, 16, instruction address width (PC width)
- DATA_W, 16, instruction word width
- TIMEOUT_CYCLES, 255, ROM ack watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- pc_addr  in  ADDR_W  current PC register value
- pc_load  out  1  drives PC load input; 0 lets the PC increment
- pc_load_val  out  ADDR_W  drives PC data_in
- rom_req  out  1  ROM read request
- rom_addr  out  ADDR_W  ROM read address
- rom_ack  in  1  ROM data valid; may be combinational with rom_req
- rom_data  in  DATA_W  ROM read data
- instr  out  DATA_W  buffered instruction
- instr_pc  out  ADDR_W  address the buffered instruction was fetched from
- instr_valid  out  1  buffer holds an instruction
- instr_ready  in  1  consumer accepts the instruction
- redirect  in  1  jump taken, one-cycle pulse
- redirect_pc  in  ADDR_W  jump target
- fetch_err  out  1  ROM timeout flag (optional feature; otherwise tied 0)

Behaviour:
- One clock domain (clk); reset is synchronous and active-high.
- Registers:
  - instr, instr_pc, instr_valid.
  - No further registers without the optional feature; the watchdog counter and fetch_err exist only with it.
- Reset values: instr=0, instr_pc=0, instr_valid=0, fetch_err=0.
- Outputs while reset=1: rom_req=0, pc_load=1, pc_load_val=0.
- Combinational outputs when reset=0 and redirect=0:
  - space = !instr_valid || instr_ready
  - rom_req = space
  - rom_addr = pc_addr
  - xfer = rom_req && rom_ack
  - pc_load = !xfer; pc_load_val = pc_addr (hold)
  - Net effect: the PC increments exactly once per accepted ROM word.
- On a rising clk edge with xfer:
  - instr <= rom_data, instr_pc <= pc_addr, instr_valid <= 1.
  - This applies even if instr_ready drained the old entry the same cycle.
- On a rising clk edge with instr_ready && instr_valid && !xfer: instr_valid <= 0.
- Throughput: 1 instruction per cycle with a zero-wait ROM (ack same cycle as req).
- Latency: ROM word visible on instr one cycle after the ack cycle.
- rom_addr stays stable while rom_req=1 and ack is pending, because the PC is held.
- Redirect has highest priority below reset. When redirect=1:
  - rom_req=0, xfer=0
  - pc_load=1, pc_load_val=redirect_pc
  - next edge: instr_valid <= 0 (the buffered instruction is flushed even if instr_ready=1)
  - Fetch resumes from redirect_pc the following cycle.
  - An ack arriving in the redirect cycle is ignored. The ROM must not hold ack across a dropped req.
- instr_ready while instr_valid=0: ignored.
- PC wrap: 16'hFFFF increments to 16'h0000 in the PC. The fetch stage does no special handling.
- Reset mid-fetch: the pending request is abandoned; the buffer is cleared.

Optional Feature:
- Macro: HACK_FETCH_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter counts consecutive cycles with rom_req=1 && rom_ack=0.
  - When the count reaches TIMEOUT_CYCLES, fetch_err is set (sticky until reset).
  - rom_req then stays 0 and the PC holds.
  - Counter clears on xfer, redirect, or reset.
- Undefined: no counter logic; fetch_err is constant 0.

Decomposition:
- Shared package hack_pkg:
  - HACK_ADDR_W=16, HACK_DATA_W=16
  - HACK_RESET_PC=16'h0000
  - hack_addr_t and hack_word_t typedefs, reused by PC and decode
- One natural sub-module: hack_fetch_watchdog, the timeout counter plus sticky flag, instantiated only under HACK_FETCH_TIMEOUT_EN.

Test Plan:
1. Zero-wait streaming: reset, then ack tied 1, ready tied 1, ROM[a]=a^16'hA5A5 → instr_pc=0,1,2,3 on consecutive cycles after the first ack; instr correct; pc_load=0 every cycle.
2. Wait states: ack after 3 cycles for each word → rom_addr stable, pc_load=1 with pc_load_val=pc_addr during waits, PC frozen; exactly one increment per ack.
3. Backpressure: ready=0 for 5 cycles with the buffer full → rom_req=0, instr/instr_pc held; ready=1 with ack=1 → replacement word loaded the same edge with no bubble.
4. Redirect: redirect=1, redirect_pc=16'h0040 while the buffer is valid and ack=1 → next cycle instr_valid=0, pc=0x0040; following fetch has rom_addr=0x0040 and instr_pc=0x0040.
5. Wrap: pc=16'hFFFF fetched → instr_pc=16'hFFFF, next rom_addr=16'h0000.
6. Timeout (HACK_FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4): ack held 0 → fetch_err=1 after 4 stalled cycles, rom_req=0; reset clears fetch_err and resumes fetch at 0.
